// File: rtl/ddr_cmd_decoder.sv
// DDR4 command/address receiver: decodes the sampled bus, tracks per-bank tRCD/tRP state, flags protocol errors.
// Command outputs are registered one clock after sampling; read/write strobes follow at CL/CWL; no backpressure.
module ddr_cmd_decoder #(
  parameter int BG_WIDTH = 2,
  parameter int BA_WIDTH = 2,
  parameter int CL       = 11,
  parameter int CWL      = 9,
  parameter int T_RCD    = 11,
  parameter int T_RP     = 11,
  localparam int BW      = BG_WIDTH + BA_WIDTH,
  localparam int NB      = 2 ** BW
) (
  input  logic                clock_t,
  input  logic                reset_n,
  input  logic                cke,
  input  logic                cs_n,
  input  logic                act_n,
  input  logic                ras_n_a16,
  input  logic                cas_n_a15,
  input  logic                we_n_a14,
  input  logic [BG_WIDTH-1:0] bg_addr,
  input  logic [BA_WIDTH-1:0] ba_addr,
  input  logic                addr17,
  input  logic                addr13,
  input  logic                bc_n_a12,
  input  logic                addr11,
  input  logic                ap_a10,
  input  logic [9:0]          addr9_0,
  output logic                cmd_valid,
  output logic [2:0]          cmd_code,
  output logic [BW-1:0]       cmd_bank,
  output logic [14:0]         cmd_row,
  output logic [9:0]          cmd_col,
  output logic [NB-1:0]       bank_open,
  output logic                rd_launch,
  output logic [BW-1:0]       rd_bank,
  output logic [9:0]          rd_col,
  output logic                wr_capture,
  output logic [BW-1:0]       wr_bank,
  output logic [9:0]          wr_col,
  output logic                proto_err,
  output logic [2:0]          err_code,
  output logic                err_sticky
);

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_PRE   = 3'd2,
    CMD_CAS_R = 3'd3,
    CMD_CAS_W = 3'd4,
    CMD_MRS   = 3'd5,
    CMD_REF   = 3'd6,
    CMD_ZQCL  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ACTIVATING  = 2'd1,
    ACTIVE      = 2'd2,
    PRECHARGING = 2'd3
  } bank_state_e;

  typedef struct packed {
    logic          vld;
    logic [BW-1:0] bank;
    logic [9:0]    col;
  } pipe_t;

  localparam logic [4:0] RCD_LOAD = 5'(T_RCD - 1);
  localparam logic [4:0] RP_LOAD  = 5'(T_RP - 1);

  cmd_e          dec_code;
  logic          dec_rsvd;
  logic [BW-1:0] sel;
  logic [2:0]    err_n;
  logic          err;
  logic          cmd_ok;
  bank_state_e   state_q [NB];
  bank_state_e   state_d [NB];
  logic [4:0]    cnt_q   [NB];
  logic [4:0]    cnt_d   [NB];
  logic [NB-1:0] open_vec;
  logic [NB-1:0] eff_idle;
  logic [NB-1:0] eff_active;
  pipe_t         rd_in;
  pipe_t         wr_in;
  pipe_t         rd_pipe [CL];
  pipe_t         wr_pipe [CWL];
  logic          unused_pins;

  assign sel         = {bg_addr, ba_addr};
  assign unused_pins = addr17;

  always_comb begin
    dec_code = CMD_NOP;
    dec_rsvd = 1'b0;
    if (cke && !cs_n) begin
      if ($isunknown({act_n, ras_n_a16, cas_n_a15, we_n_a14})) begin
        dec_rsvd = 1'b1;
      end else if (!act_n) begin
        dec_code = CMD_ACT;
      end else begin
        case ({ras_n_a16, cas_n_a15, we_n_a14})
          3'b000:  dec_code = CMD_MRS;
          3'b001:  dec_code = CMD_REF;
          3'b010:  dec_code = CMD_PRE;
          3'b011:  dec_rsvd = 1'b1;
          3'b100:  dec_code = CMD_CAS_W;
          3'b101:  dec_code = CMD_CAS_R;
          3'b110:  dec_code = CMD_ZQCL;
          default: dec_code = CMD_NOP;
        endcase
      end
    end
  end

  // A bank whose counter has expired counts as already in its next state,
  // so a command exactly tRCD/tRP after ACT/PRE is accepted.
  always_comb begin
    for (int b = 0; b < NB; b++) begin
      open_vec[b]   = (state_q[b] == ACTIVATING) || (state_q[b] == ACTIVE);
      eff_active[b] = (state_q[b] == ACTIVE) ||
                      ((state_q[b] == ACTIVATING) && (cnt_q[b] == 5'd0));
      eff_idle[b]   = (state_q[b] == IDLE) ||
                      ((state_q[b] == PRECHARGING) && (cnt_q[b] == 5'd0));
    end
  end

  always_comb begin
    err_n = 3'd0;
    case (dec_code)
      CMD_ACT:              if (!eff_idle[sel])   err_n = 3'd1;
      CMD_CAS_R, CMD_CAS_W: if (!eff_active[sel]) err_n = 3'd2;
      CMD_REF:              if (|open_vec)        err_n = 3'd3;
      CMD_MRS:              if (|open_vec)        err_n = 3'd5;
      default:              err_n = 3'd0;
    endcase
    if (dec_rsvd) err_n = 3'd4;
  end

  assign err    = (err_n != 3'd0);
  assign cmd_ok = !err;

  always_comb begin
    for (int b = 0; b < NB; b++) begin
      state_d[b] = state_q[b];
      cnt_d[b]   = (cnt_q[b] == 5'd0) ? 5'd0 : cnt_q[b] - 5'd1;
      if ((state_q[b] == ACTIVATING) && (cnt_q[b] == 5'd0)) state_d[b] = ACTIVE;
      if ((state_q[b] == PRECHARGING) && (cnt_q[b] == 5'd0)) state_d[b] = IDLE;
      if (cmd_ok && (sel == BW'(b))) begin
        case (dec_code)
          CMD_ACT: begin
            state_d[b] = ACTIVATING;
            cnt_d[b]   = RCD_LOAD;
          end
          CMD_PRE: begin
            if (open_vec[b]) begin
              state_d[b] = PRECHARGING;
              cnt_d[b]   = RP_LOAD;
            end
          end
          CMD_CAS_R, CMD_CAS_W: begin
            if (ap_a10) begin
              state_d[b] = PRECHARGING;
              cnt_d[b]   = RP_LOAD;
            end
          end
          default: state_d[b] = state_d[b];
        endcase
      end
    end
  end

  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= IDLE;
        cnt_q[b]   <= 5'd0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        state_q[b] <= state_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
    end
  end

  always_comb begin
    rd_in = {cmd_ok && (dec_code == CMD_CAS_R), sel, addr9_0};
    wr_in = {cmd_ok && (dec_code == CMD_CAS_W), sel, addr9_0};
  end

  always_ff @(posedge clock_t) begin
    if (!reset_n) begin
      for (int i = 0; i < CL; i++)  rd_pipe[i] <= '0;
      for (int i = 0; i < CWL; i++) wr_pipe[i] <= '0;
      cmd_valid  <= 1'b0;
      cmd_code   <= 3'd0;
      cmd_bank   <= '0;
      cmd_row    <= 15'd0;
      cmd_col    <= 10'd0;
      proto_err  <= 1'b0;
      err_code   <= 3'd0;
      err_sticky <= 1'b0;
    end else begin
      rd_pipe[0] <= rd_in;
      for (int i = 1; i < CL; i++)  rd_pipe[i] <= rd_pipe[i-1];
      wr_pipe[0] <= wr_in;
      for (int i = 1; i < CWL; i++) wr_pipe[i] <= wr_pipe[i-1];
      cmd_valid  <= (dec_code != CMD_NOP);
      cmd_code   <= dec_code;
      cmd_bank   <= sel;
      cmd_row    <= {we_n_a14, addr13, bc_n_a12, addr11, ap_a10, addr9_0};
      cmd_col    <= addr9_0;
      proto_err  <= err;
      err_code   <= err_n;
      err_sticky <= err_sticky | err;
    end
  end

  assign bank_open  = open_vec;
  assign rd_launch  = rd_pipe[CL-1].vld;
  assign rd_bank    = rd_pipe[CL-1].bank;
  assign rd_col     = rd_pipe[CL-1].col;
  assign wr_capture = wr_pipe[CWL-1].vld;
  assign wr_bank    = wr_pipe[CWL-1].bank;
  assign wr_col     = wr_pipe[CWL-1].col;

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Directed bench for ddr_cmd_decoder; stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_ddr_cmd_decoder;

  localparam int CL  = 11;
  localparam int CWL = 9;
  localparam int K_ACT = 1, K_PRE = 2, K_RD = 3, K_WR = 4, K_MRS = 5, K_REF = 6, K_ZQ = 7, K_RSVD = 8;

  logic        clock_t = 1'b0;
  logic        reset_n = 1'b0;
  logic        cke = 1'b1, cs_n = 1'b1, act_n = 1'b1;
  logic        ras_n_a16 = 1'b1, cas_n_a15 = 1'b1, we_n_a14 = 1'b1;
  logic [1:0]  bg_addr = 2'd0, ba_addr = 2'd0;
  logic        addr17 = 1'b0, addr13 = 1'b0, bc_n_a12 = 1'b0, addr11 = 1'b0, ap_a10 = 1'b0;
  logic [9:0]  addr9_0 = 10'd0;

  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [3:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [15:0] bank_open;
  logic        rd_launch;
  logic [3:0]  rd_bank;
  logic [9:0]  rd_col;
  logic        wr_capture;
  logic [3:0]  wr_bank;
  logic [9:0]  wr_col;
  logic        proto_err;
  logic [2:0]  err_code;
  logic        err_sticky;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct { int cyc; int code; logic [3:0] bank; logic [14:0] row; logic [9:0] col; } cmd_exp_t;
  typedef struct { int cyc; int code; } err_exp_t;
  typedef struct { int cyc; logic [3:0] bank; logic [9:0] col; } strb_exp_t;

  cmd_exp_t  cmd_q[$];
  err_exp_t  err_q[$];
  strb_exp_t rd_q[$];
  strb_exp_t wr_q[$];
  cmd_exp_t  mc;
  err_exp_t  me;
  strb_exp_t ms;

  ddr_cmd_decoder #(
    .BG_WIDTH(2), .BA_WIDTH(2), .CL(CL), .CWL(CWL), .T_RCD(11), .T_RP(11)
  ) dut (
    .clock_t(clock_t), .reset_n(reset_n), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .ras_n_a16(ras_n_a16), .cas_n_a15(cas_n_a15), .we_n_a14(we_n_a14),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .addr17(addr17), .addr13(addr13),
    .bc_n_a12(bc_n_a12), .addr11(addr11), .ap_a10(ap_a10), .addr9_0(addr9_0),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
    .cmd_col(cmd_col), .bank_open(bank_open), .rd_launch(rd_launch), .rd_bank(rd_bank),
    .rd_col(rd_col), .wr_capture(wr_capture), .wr_bank(wr_bank), .wr_col(wr_col),
    .proto_err(proto_err), .err_code(err_code), .err_sticky(err_sticky)
  );

  always #5 clock_t = ~clock_t;
  always @(posedge clock_t) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: output asserted at cycle %0d, expected none", name, cyc);
  endtask

  always @(negedge clock_t) begin
    if (cmd_valid) begin
      if (cmd_q.size() == 0) unexpected("cmd_valid");
      else begin
        mc = cmd_q.pop_front();
        check("cmd_cycle", cyc, mc.cyc);
        check("cmd_code", {29'd0, cmd_code}, mc.code);
        check("cmd_bank", {28'd0, cmd_bank}, {28'd0, mc.bank});
        if (mc.code == K_ACT) check("cmd_row", {17'd0, cmd_row}, {17'd0, mc.row});
        if (mc.code == K_RD || mc.code == K_WR) check("cmd_col", {22'd0, cmd_col}, {22'd0, mc.col});
      end
    end
    if (proto_err) begin
      if (err_q.size() == 0) unexpected("proto_err");
      else begin
        me = err_q.pop_front();
        check("err_cycle", cyc, me.cyc);
        check("err_code", {29'd0, err_code}, me.code);
      end
    end
    if (rd_launch) begin
      if (rd_q.size() == 0) unexpected("rd_launch");
      else begin
        ms = rd_q.pop_front();
        check("rd_cycle", cyc, ms.cyc);
        check("rd_bank", {28'd0, rd_bank}, {28'd0, ms.bank});
        check("rd_col", {22'd0, rd_col}, {22'd0, ms.col});
      end
    end
    if (wr_capture) begin
      if (wr_q.size() == 0) unexpected("wr_capture");
      else begin
        ms = wr_q.pop_front();
        check("wr_cycle", cyc, ms.cyc);
        check("wr_bank", {28'd0, wr_bank}, {28'd0, ms.bank});
        check("wr_col", {22'd0, wr_col}, {22'd0, ms.col});
      end
    end
  end

  task automatic drive(input int kind, input logic [3:0] bank, input logic [14:0] a, input logic ap);
    cs_n  = 1'b0;
    act_n = 1'b1;
    {bg_addr, ba_addr} = bank;
    {we_n_a14, addr13, bc_n_a12, addr11, ap_a10, addr9_0} = a;
    ras_n_a16 = 1'b1;
    cas_n_a15 = 1'b1;
    case (kind)
      K_ACT:  act_n = 1'b0;
      K_PRE:  {ras_n_a16, cas_n_a15, we_n_a14} = 3'b010;
      K_RD:   begin {ras_n_a16, cas_n_a15, we_n_a14} = 3'b101; ap_a10 = ap; end
      K_WR:   begin {ras_n_a16, cas_n_a15, we_n_a14} = 3'b100; ap_a10 = ap; end
      K_MRS:  {ras_n_a16, cas_n_a15, we_n_a14} = 3'b000;
      K_REF:  {ras_n_a16, cas_n_a15, we_n_a14} = 3'b001;
      K_ZQ:   {ras_n_a16, cas_n_a15, we_n_a14} = 3'b110;
      default: {ras_n_a16, cas_n_a15, we_n_a14} = 3'b011;
    endcase
  endtask

  // Issues one command for the next rising edge and queues what it must produce.
  task automatic cmd(input int kind, input logic [3:0] bank, input logic [14:0] a,
                     input logic ap, input int exp_err);
    int        e;
    cmd_exp_t  c;
    err_exp_t  r;
    strb_exp_t s;
    e = cyc + 1;
    drive(kind, bank, a, ap);
    if (kind != K_RSVD) begin
      c.cyc = e; c.code = kind; c.bank = bank; c.row = a; c.col = a[9:0];
      cmd_q.push_back(c);
    end
    if (exp_err != 0) begin
      r.cyc = e; r.code = exp_err;
      err_q.push_back(r);
    end else if (kind == K_RD) begin
      s.cyc = e + CL - 1; s.bank = bank; s.col = a[9:0];
      rd_q.push_back(s);
    end else if (kind == K_WR) begin
      s.cyc = e + CWL - 1; s.bank = bank; s.col = a[9:0];
      wr_q.push_back(s);
    end
    @(negedge clock_t);
    cs_n = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock_t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clock_t);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    check("rst_bank_open", {16'd0, bank_open}, 0);
    check("rst_err_sticky", {31'd0, err_sticky}, 0);
    check("rst_rd_launch", {31'd0, rd_launch}, 0);
    check("rst_wr_capture", {31'd0, wr_capture}, 0);
    reset_n = 1'b1;
    idle(1);

    // ACT bank 5 then CAS_R exactly tRCD later
    cmd(K_ACT, 4'd5, 15'h1234, 1'b0, 0);
    check("open_after_act", {16'd0, bank_open}, 32'h0020);
    idle(10);
    cmd(K_RD, 4'd5, 15'h003A, 1'b0, 0);
    check("sticky_clean", {31'd0, err_sticky}, 0);

    // CAS_W one cycle early
    cmd(K_ACT, 4'd2, 15'h0456, 1'b0, 0);
    idle(9);
    cmd(K_WR, 4'd2, 15'h0011, 1'b0, 2);
    check("sticky_set", {31'd0, err_sticky}, 1);

    // auto-precharge then ACT at tRP-1 and tRP
    cmd(K_ACT, 4'd0, 15'h0777, 1'b0, 0);
    idle(10);
    cmd(K_WR, 4'd0, 15'h0015, 1'b1, 0);
    check("open_after_ap", {16'd0, bank_open}, 32'h0024);
    idle(9);
    cmd(K_ACT, 4'd0, 15'h0100, 1'b0, 1);
    cmd(K_ACT, 4'd0, 15'h0100, 1'b0, 0);

    // back-to-back reads to four banks
    cmd(K_ACT, 4'd1, 15'h0101, 1'b0, 0);
    cmd(K_ACT, 4'd3, 15'h0303, 1'b0, 0);
    idle(10);
    for (int b = 0; b < 4; b++) cmd(K_RD, 4'(b), 15'(256 + b), 1'b0, 0);

    // REF with bank 7 open, then an ACT pattern while cke is low
    cmd(K_ACT, 4'd7, 15'h0042, 1'b0, 0);
    cmd(K_REF, 4'd0, 15'h0000, 1'b0, 3);
    cke = 1'b0;
    drive(K_ACT, 4'd8, 15'h0099, 1'b0);
    @(negedge clock_t);
    cke  = 1'b1;
    cs_n = 1'b1;
    idle(1);
    check("open_cke_low", {16'd0, bank_open}, 32'h00AF);

    cmd(K_MRS, 4'd0, 15'h0000, 1'b0, 5);
    cmd(K_RSVD, 4'd4, 15'h0000, 1'b0, 4);
    cmd(K_PRE, 4'd9, 15'h0000, 1'b0, 0);
    cmd(K_ZQ, 4'd0, 15'h0400, 1'b0, 0);
    cmd(K_PRE, 4'd7, 15'h0000, 1'b0, 0);
    check("open_after_pre", {16'd0, bank_open}, 32'h002F);
    idle(15);

    // reset with a read three cycles into its pipeline: that strobe must never appear
    cmd(K_RD, 4'd5, 15'h0077, 1'b0, 0);
    void'(rd_q.pop_back());
    idle(2);
    reset_n = 1'b0;
    @(negedge clock_t);
    check("rst2_bank_open", {16'd0, bank_open}, 0);
    check("rst2_err_sticky", {31'd0, err_sticky}, 0);
    check("rst2_cmd_valid", {31'd0, cmd_valid}, 0);
    reset_n = 1'b1;
    idle(20);

    check("cmd_q_left", cmd_q.size(), 0);
    check("err_q_left", err_q.size(), 0);
    check("rd_q_left", rd_q.size(), 0);
    check("wr_q_left", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
